sram_sdp_bw: RTL and testbench
==============================

# sram_sdp_bw

Parametrised single-clock simple-dual-port SRAM for NPU on-chip buffers; successor to the fixed 128x4096 two-clock buffer. Adds per-byte write enables, selectable read latency, a defined read-during-write policy, a read-valid strobe and an optional post-reset zero-fill sequencer. One write port (A) and one read port (B) share a single clock. Port A and port B are independent and may both be active in the same cycle.

## Interface
- DATA_W, 128, data width in bits; must be a multiple of BYTE_W
- DEPTH, 4096, number of words; need not be a power of two
- BYTE_W, 8, bits per write-enable lane; NB = DATA_W/BYTE_W lanes
- RD_LAT, 1, read latency in cycles; legal values 1 or 2
- RDW_MODE, 0, same-address read-during-write result: 0 = old data, 1 = new data (forwarded)
- INIT_CLEAR, 1, 1 = zero-fill whole array after reset; 0 = no fill
- AW = max(1, clog2(DEPTH)), derived, not overridable
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ena  in  1  write port enable
- wea  in  NB  per-lane write enable; lane i covers dina[i*BYTE_W +: BYTE_W]
- addra  in  AW  write address
- dina  in  DATA_W  write data
- enb  in  1  read port enable
- addrb  in  AW  read address
- doutb  out  DATA_W  read data; held between reads
- doutb_vld  out  1  one-cycle strobe, doutb carries new read data
- init_busy  out  1  zero-fill in progress; ports ignored while high

## Operation
- Write: when ena && !init_busy, lane i of mem[addra] <= dina lane i for each wea[i]=1; other lanes unchanged. ena with wea=0 is a no-op.
- Read: when enb && !init_busy, a read of mem[addrb] is issued; result appears RD_LAT cycles later with doutb_vld=1.
- Read-during-write, same address, same cycle: RDW_MODE=0 returns pre-write word; RDW_MODE=1 returns byte-merged word (written lanes from dina, others from array). Comparison only at issue cycle; a write in the following cycle does not alter an in-flight read.
- Out-of-range address (>= DEPTH): write dropped; read returns all-zero with doutb_vld=1.
- doutb and all pipeline data stages hold value when no valid read advances; only doutb_vld returns to 0.
- Zero-fill FSM (INIT_CLEAR=1), states RST, FILL, RUN:
  - RST: while rst=1; counter=0, init_busy=1.
  - FILL: first cycle after rst falls; writes 0 to mem[counter], counter+1 per cycle; at counter=DEPTH-1 writes last word, next state RUN.
  - RUN: init_busy=0; normal operation until rst.
  - INIT_CLEAR=0: FSM stays RUN after reset; init_busy=0 from the first cycle rst is low. Array content after power-up undefined.
- Reset mid-operation: in-flight reads discarded (doutb_vld=0), doutb=0, fill restarts at address 0; array content not preserved when INIT_CLEAR=1.

## Timing
- Reset values: doutb=0, doutb_vld=0, init_busy=1 if INIT_CLEAR=1 else 0 (init_busy is 1 during rst in both cases so no access occurs in reset).
- Read issued at edge t -> doutb/doutb_vld valid after edge t+RD_LAT. Back-to-back reads: one result per cycle, no bubbles.
- Write visible to a read issued at the next edge or later regardless of RDW_MODE.
- Fill duration: exactly DEPTH cycles with init_busy=1 after rst deasserts; first accepted access on cycle DEPTH after rst low.
- Read issued in last FILL cycle is ignored (init_busy still 1).

## Structure
- Package sram_pkg: RDW_OLD=0 / RDW_NEW=1 constants, state enum {ST_RST, ST_FILL, ST_RUN}, clog2 helper.
- Parameter legality (RD_LAT in {1,2}, DATA_W % BYTE_W == 0) checked at elaboration.
- One sub-module natural: sram_fill_seq (FSM + counter, drives internal write mux and init_busy). Array, byte-merge and read pipeline stay in top.

## Test plan
- Reset, INIT_CLEAR=1, DEPTH=4096: init_busy high for 4096 cycles after rst low; read addr 0xFFF then returns 0, doutb_vld at RD_LAT.
- Byte enables: write 0xFF..FF to addr 5, then wea=16'h0001 with dina=0 -> read addr 5 returns 0xFF..FF00.
- RDW same address: array holds A, write B same cycle as read -> RDW_MODE=0 returns A, RDW_MODE=1 returns B; with wea=16'h00FF returns upper lanes of A, lower of B.
- Latency: RD_LAT=2, reads addr 1,2,3 on consecutive cycles -> three consecutive doutb_vld pulses, data in order, starting 2 cycles after first issue; doutb holds last value afterward.
- DEPTH=3000: write to 3500 dropped, read 3500 returns 0 with doutb_vld=1; addr 2999 read/write normal.
- rst asserted with 2 reads in flight (RD_LAT=2): no doutb_vld, doutb=0, fill restarts at 0 and lasts DEPTH cycles.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared constants, FSM state type and sizing helpers for the byte-write SRAM.
package sram_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  typedef enum logic [1:0] {
    ST_RST,
    ST_FILL,
    ST_RUN
  } state_e;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

  // Address width for a given depth, never narrower than one bit.
  function automatic int addr_w(input int depth);
    int a;
    a = clog2(depth);
    return (a < 1) ? 1 : a;
  endfunction

endpackage

// File: rtl/sram_sdp_bw_if.sv
// Write port A, read port B and status of the simple-dual-port SRAM.
interface sram_sdp_bw_if #(
  parameter int DATA_W = 128,
  parameter int BYTE_W = 8,
  parameter int AW     = 12
);
  localparam int NB = DATA_W / BYTE_W;

  logic              ena;
  logic [NB-1:0]     wea;
  logic [AW-1:0]     addra;
  logic [DATA_W-1:0] dina;
  logic              enb;
  logic [AW-1:0]     addrb;
  logic [DATA_W-1:0] doutb;
  logic              doutb_vld;
  logic              init_busy;

  modport master (
    output ena, wea, addra, dina, enb, addrb,
    input  doutb, doutb_vld, init_busy
  );

  modport slave (
    input  ena, wea, addra, dina, enb, addrb,
    output doutb, doutb_vld, init_busy
  );
endinterface

// File: rtl/sram_fill_seq.sv
// Post-reset zero-fill sequencer: walks every address once, then releases the ports.
module sram_fill_seq
  import sram_pkg::*;
#(
  parameter int DEPTH      = 4096,
  parameter int AW         = 12,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          fill_we,
  output logic [AW-1:0] fill_addr,
  output logic          init_busy
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e        state_q, state_d, state_cur;
  logic [AW-1:0] cnt_q, cnt_d;

  // State and counter registers; reset parks the FSM at the first fill address.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (INIT_CLEAR) state_q <= ST_FILL;
      else            state_q <= ST_RUN;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and outputs; a high rst is seen as ST_RST so no access slips through.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fill_we   = 1'b0;
    fill_addr = cnt_q;
    init_busy = 1'b1;
    if (rst) state_cur = ST_RST;
    else     state_cur = state_q;
    case (state_cur)
      ST_FILL: begin
        fill_we = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN:  init_busy = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: rtl/sram_sdp_bw.sv
// Single-clock simple-dual-port SRAM with byte write enables, 1/2-cycle read
// latency, selectable read-during-write result and optional zero-fill.
module sram_sdp_bw
  import sram_pkg::*;
#(
  parameter int DATA_W     = 128,
  parameter int DEPTH      = 4096,
  parameter int BYTE_W     = 8,
  parameter int RD_LAT     = 1,
  parameter int RDW_MODE   = RDW_OLD,
  parameter int INIT_CLEAR = 1
) (
  input  logic         clk,
  input  logic         rst,
  sram_sdp_bw_if.slave bus
);

  localparam int AW = addr_w(DEPTH);
  localparam int NB = DATA_W / BYTE_W;
  localparam logic [AW:0] DEPTH_X = (AW + 1)'(DEPTH);

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("sram_sdp_bw: RD_LAT must be 1 or 2");
  end
  if (DATA_W % BYTE_W != 0) begin : g_bad_lane
    $error("sram_sdp_bw: DATA_W must be a multiple of BYTE_W");
  end

  logic              init_busy, fill_we;
  logic [AW-1:0]     fill_addr;
  logic              wa_ok, rb_ok, user_we, rd_go;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [NB-1:0]     wr_be;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_word;
  logic              vld1;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] mem [DEPTH];

  sram_fill_seq #(
    .DEPTH      (DEPTH),
    .AW         (AW),
    .INIT_CLEAR (INIT_CLEAR != 0)
  ) u_fill (
    .clk       (clk),
    .rst       (rst),
    .fill_we   (fill_we),
    .fill_addr (fill_addr),
    .init_busy (init_busy)
  );

  assign bus.init_busy = init_busy;
  assign wa_ok   = {1'b0, bus.addra} < DEPTH_X;
  assign rb_ok   = {1'b0, bus.addrb} < DEPTH_X;
  assign user_we = bus.ena && !init_busy && wa_ok;
  assign rd_go   = bus.enb && !init_busy;

  // Write mux: the fill sequencer owns the array while busy, port A otherwise.
  always_comb begin
    wr_en   = user_we;
    wr_addr = bus.addra;
    wr_be   = bus.wea;
    wr_data = bus.dina;
    if (fill_we) begin
      wr_en   = 1'b1;
      wr_addr = fill_addr;
      wr_be   = '1;
      wr_data = '0;
    end
  end

  // Array write, one enable per byte lane.
  // NOTE: the array has no reset; clearing it is the fill sequencer's job, keeping it RAM-inferable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Read word at issue: zero when out of range, written lanes forwarded in new-data mode.
  always_comb begin
    rd_word = '0;
    if (rb_ok) begin
      rd_word = mem[bus.addrb];
      if (RDW_MODE == RDW_NEW && user_we && bus.addra == bus.addrb) begin
        for (int i = 0; i < NB; i++) begin
          if (bus.wea[i]) rd_word[i*BYTE_W +: BYTE_W] = bus.dina[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // First read stage; data only moves on an issued read so it holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld1  <= 1'b0;
      data1 <= '0;
    end else begin
      vld1 <= rd_go;
      if (rd_go) data1 <= rd_word;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              vld2;
    logic [DATA_W-1:0] data2;

    // Second read stage, same hold behaviour as the first.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld2  <= 1'b0;
        data2 <= '0;
      end else begin
        vld2 <= vld1;
        if (vld1) data2 <= data1;
      end
    end

    assign bus.doutb     = data2;
    assign bus.doutb_vld = vld2;
  end else begin : g_lat1
    assign bus.doutb     = data1;
    assign bus.doutb_vld = vld1;
  end

endmodule

// File: tb/tb_sram_sdp_bw.sv
// Two configurations driven in lockstep: A = 4096 deep, 1-cycle, old-data;
// B = 3000 deep, 2-cycle, new-data. A monitor checks every read strobe
// against queued expectations, including its arrival cycle.
module tb_sram_sdp_bw;
  import sram_pkg::*;

  localparam int DW    = 128;
  localparam int NB    = 16;
  localparam int AW    = addr_w(4096);
  localparam int LAT_A = 1;
  localparam int LAT_B = 2;

  localparam logic [DW-1:0] ALL1 = '1;
  localparam logic [DW-1:0] LOW0 = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF00;
  localparam logic [DW-1:0] P    = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [DW-1:0] Q    = 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978;
  localparam logic [DW-1:0] QP   = 128'hFEDCBA98_76543210_8899AABB_CCDDEEFF;
  localparam logic [DW-1:0] V1   = {16{8'h11}};
  localparam logic [DW-1:0] V2   = {16{8'h22}};
  localparam logic [DW-1:0] V3   = {16{8'h33}};
  localparam logic [DW-1:0] V4   = {16{8'h44}};
  localparam logic [DW-1:0] V5   = {16{8'h55}};

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   ba, bb;
  exp_t qa[$], qb[$];
  exp_t mon_a, mon_b;

  sram_sdp_bw_if #(.DATA_W(DW), .BYTE_W(8), .AW(AW)) ia ();
  sram_sdp_bw_if #(.DATA_W(DW), .BYTE_W(8), .AW(AW)) ib ();

  sram_sdp_bw #(.DATA_W(DW), .DEPTH(4096), .BYTE_W(8), .RD_LAT(LAT_A),
                .RDW_MODE(RDW_OLD), .INIT_CLEAR(1))
    u_a (.clk(clk), .rst(rst), .bus(ia));

  sram_sdp_bw #(.DATA_W(DW), .DEPTH(3000), .BYTE_W(8), .RD_LAT(LAT_B),
                .RDW_MODE(RDW_NEW), .INIT_CLEAR(1))
    u_b (.clk(clk), .rst(rst), .bus(ib));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check_d(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic check_i(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every read strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (ia.doutb_vld) begin
      if (qa.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected_vld act=%h exp=no read pending", ia.doutb);
      end else begin
        mon_a = qa.pop_front();
        check_d("a_rdata", ia.doutb, mon_a.data);
        check_i("a_latency", cyc, mon_a.due);
      end
    end
    if (ib.doutb_vld) begin
      if (qb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected_vld act=%h exp=no read pending", ib.doutb);
      end else begin
        mon_b = qb.pop_front();
        check_d("b_rdata", ib.doutb, mon_b.data);
        check_i("b_latency", cyc, mon_b.due);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of port inputs to both DUTs and queue expected read results.
  task automatic apply(input logic ena, input logic [NB-1:0] wea, input logic [AW-1:0] aa,
                       input logic [DW-1:0] di, input logic enb, input logic [AW-1:0] ab,
                       input logic pa, input logic [DW-1:0] ea,
                       input logic pb, input logic [DW-1:0] eb);
    ia.ena = ena; ia.wea = wea; ia.addra = aa; ia.dina = di; ia.enb = enb; ia.addrb = ab;
    ib.ena = ena; ib.wea = wea; ib.addra = aa; ib.dina = di; ib.enb = enb; ib.addrb = ab;
    if (pa) qa.push_back('{ea, cyc + LAT_A});
    if (pb) qb.push_back('{eb, cyc + LAT_B});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      apply(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
      nxt();
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [NB-1:0] wea, input logic [DW-1:0] d);
    apply(1'b1, wea, a, d, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    nxt();
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] ea, input logic [DW-1:0] eb);
    apply(1'b0, '0, '0, '0, 1'b1, a, 1'b1, ea, 1'b1, eb);
    nxt();
  endtask

  task automatic rw(input logic [AW-1:0] wa, input logic [NB-1:0] wea, input logic [DW-1:0] d,
                    input logic [AW-1:0] ra, input logic [DW-1:0] ea, input logic [DW-1:0] eb);
    apply(1'b1, wea, wa, d, 1'b1, ra, 1'b1, ea, 1'b1, eb);
    nxt();
  endtask

  // Count busy cycles from the first cycle with rst low, no port activity.
  task automatic count_fill(output int na, output int nb);
    na = 0;
    nb = 0;
    for (int p = 0; p < 4100; p++) begin
      apply(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
      @(negedge clk);
      if (ia.init_busy) na++;
      if (ib.init_busy) nb++;
      nxt();
    end
  endtask

  initial begin
    apply(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    repeat (3) nxt();
    @(negedge clk);
    check_d("a_rst_doutb", ia.doutb, '0);
    check_i("a_rst_vld", int'(ia.doutb_vld), 0);
    check_i("a_rst_busy", int'(ia.init_busy), 1);
    check_d("b_rst_doutb", ib.doutb, '0);
    check_i("b_rst_vld", int'(ib.doutb_vld), 0);
    check_i("b_rst_busy", int'(ib.init_busy), 1);
    nxt();
    rst = 1'b0;

    // First fill with reads of 0xFFF in B's last fill cycle, A's last fill
    // cycle and A's first free cycle.
    ba = 0;
    bb = 0;
    for (int p = 0; p < 4100; p++) begin
      if (p == 2999)
        apply(1'b0, '0, '0, '0, 1'b1, 12'hFFF, 1'b0, '0, 1'b0, '0);
      else if (p == 4095)
        apply(1'b0, '0, '0, '0, 1'b1, 12'hFFF, 1'b0, '0, 1'b1, '0);
      else if (p == 4096)
        apply(1'b0, '0, '0, '0, 1'b1, 12'hFFF, 1'b1, '0, 1'b1, '0);
      else
        apply(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
      @(negedge clk);
      if (ia.init_busy) ba++;
      if (ib.init_busy) bb++;
      nxt();
    end
    check_i("a_fill_len", ba, 4096);
    check_i("b_fill_len", bb, 3000);

    // Byte enables.
    wr(12'd5, 16'hFFFF, ALL1);
    wr(12'd5, 16'h0001, '0);
    rd(12'd5, LOW0, LOW0);

    // Same-address read during write.
    wr(12'd6, 16'hFFFF, P);
    rw(12'd6, 16'hFFFF, Q, 12'd6, P, Q);
    rd(12'd6, Q, Q);
    rw(12'd6, 16'h00FF, P, 12'd6, Q, QP);
    rd(12'd6, QP, QP);
    rw(12'd6, 16'h0000, '0, 12'd6, QP, QP);

    // Back-to-back reads, then hold.
    wr(12'd1, 16'hFFFF, V1);
    wr(12'd2, 16'hFFFF, V2);
    wr(12'd3, 16'hFFFF, V3);
    rd(12'd1, V1, V1);
    rd(12'd2, V2, V2);
    rd(12'd3, V3, V3);
    idle(4);
    @(negedge clk);
    check_d("a_hold", ia.doutb, V3);
    check_d("b_hold", ib.doutb, V3);
    check_i("a_vld_low", int'(ia.doutb_vld), 0);
    check_i("b_vld_low", int'(ib.doutb_vld), 0);

    // A write in the cycle after a read leaves the in-flight read alone.
    rd(12'd1, V1, V1);
    rw(12'd1, 16'hFFFF, V4, 12'd2, V2, V2);
    rd(12'd1, V4, V4);

    // Out-of-range on B (3500 is a normal address for A), last word of B.
    wr(12'd3500, 16'hFFFF, ALL1);
    rd(12'd3500, ALL1, '0);
    wr(12'd2999, 16'hFFFF, V5);
    rd(12'd2999, V5, V5);
    idle(3);

    // Reset with reads in flight: A's first read lands before reset, B's does not.
    apply(1'b0, '0, '0, '0, 1'b1, 12'd1, 1'b1, V4, 1'b0, '0);
    nxt();
    apply(1'b0, '0, '0, '0, 1'b1, 12'd2, 1'b0, '0, 1'b0, '0);
    rst = 1'b1;
    nxt();
    nxt();
    @(negedge clk);
    check_d("a_mid_rst_doutb", ia.doutb, '0);
    check_i("a_mid_rst_vld", int'(ia.doutb_vld), 0);
    check_d("b_mid_rst_doutb", ib.doutb, '0);
    check_i("b_mid_rst_vld", int'(ib.doutb_vld), 0);
    nxt();
    rst = 1'b0;
    count_fill(ba, bb);
    check_i("a_refill_len", ba, 4096);
    check_i("b_refill_len", bb, 3000);
    rd(12'd5, '0, '0);
    rd(12'd2999, '0, '0);
    idle(4);

    check_i("a_queue_empty", qa.size(), 0);
    check_i("b_queue_empty", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
